load_store_unit: RTL and testbench

Sits between the core's execute stage and the word-organised data memory, upstream of the memory's address/write_data/byte_enable/write_enable port. Accepts one byte, halfword or word load/store per handshake, converts it to an aligned word access with byte enables and replicated store data, and extracts and sign- or zero-extends load data. Misaligned, reserved-size and out-of-range accesses are trapped here and never reach memory. Memory reads are combinational and writes are synchronous.

---
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Converts one byte/halfword/word load or store per handshake into an
//   aligned word access on a word-organised data memory. Stores get byte
//   enables and lane-replicated data; loads are extracted from the read word
//   and sign- or zero-extended. Misaligned, reserved-size and out-of-range
//   accesses are reported on rsp_error and never strobe the memory.
//
// Ports:
//   clk, nrst          clock, synchronous active-low reset
//   req_valid/ready    request handshake (req_ready high only in IDLE)
//   req_write          1 = store, 0 = load
//   req_size           00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned       load zero-extend (1) / sign-extend (0)
//   req_addr/wdata     byte address, right-justified store data
//   rsp_valid/ready    response handshake
//   rsp_rdata          extended load data (0 for stores and errors)
//   rsp_error          access trapped
//   mem_*              word-aligned memory port; mem_read_data is combinational
module load_store_unit #(
  parameter int unsigned WORDS = 128
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic        err;
  logic [3:0]  be;
  logic [31:0] lane;
  logic [31:0] load_data;

  // Error detection on the captured request
  always_comb begin
    err = 1'b0;
    case (size_q)
      2'b01:   err = addr_q[0];
      2'b10:   err = (addr_q[1:0] != 2'b00);
      2'b11:   err = 1'b1;
      default: err = 1'b0;
    endcase
    if ({2'b00, addr_q[31:2]} >= WORDS) err = 1'b1;
  end

  // Byte enables, replicated store data and load extraction
  always_comb begin
    be             = 4'b1111;
    mem_write_data = wdata_q;
    lane           = mem_read_data >> {addr_q[1:0], 3'b000};
    load_data      = lane;
    case (size_q)
      2'b00: begin
        be             = 4'b0001 << addr_q[1:0];
        mem_write_data = {4{wdata_q[7:0]}};
        load_data      = unsigned_q ? {24'h0, lane[7:0]}
                                    : {{24{lane[7]}}, lane[7:0]};
      end
      2'b01: begin
        be             = 4'b0011 << {addr_q[1], 1'b0};
        mem_write_data = {2{wdata_q[15:0]}};
        load_data      = unsigned_q ? {16'h0, lane[15:0]}
                                    : {{16{lane[15]}}, lane[15:0]};
      end
      default: ;
    endcase
  end

  // Address and store data come straight from the captured registers, so
  // they hold their last values outside ACCESS without extra flops.
  assign mem_address      = {addr_q[31:2], 2'b00};
  assign mem_write_enable = (state == ACCESS) && !err && write_q;
  assign mem_byte_enable  = mem_write_enable ? be : '0;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        write_q    <= req_write;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
      end
      if (state == ACCESS) begin
        rdata_q <= (err || write_q) ? '0 : load_data;
        error_q <= err;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_write_enable;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WORDS(128)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_byte_enable(mem_byte_enable), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data)
  );

  // Simple word memory: combinational read, byte-enabled synchronous write
  logic [31:0] mem [0:127];
  logic        mem_clr;
  assign mem_read_data = mem[mem_address[8:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (mem_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[b]) mem[mem_address[8:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;    // expected byte enables in ACCESS
    logic [31:0] mwd;   // expected mem_write_data (non-error stores)
    logic [31:0] rd;    // expected rsp_rdata
    logic        err;   // expected rsp_error
  } vec_t;

  vec_t vecs[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(logic wr, logic [1:0] sz, logic uns, logic [31:0] addr,
                              logic [31:0] wd, logic [3:0] be, logic [31:0] mwd,
                              logic [31:0] rd, logic err);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
    v.be = be; v.mwd = mwd; v.rd = rd; v.err = err;
    return v;
  endfunction

  task automatic drive_req(input vec_t v);
    req_write = v.wr; req_size = v.sz; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wd; req_valid = 1'b1;
  endtask

  // One full transaction with rsp_ready held high
  task automatic run_vec(input vec_t v);
    logic [31:0] exp_addr;
    exp_addr = {v.addr[31:2], 2'b00};
    @(negedge clk);
    chk("idle_req_ready", {31'h0, req_ready}, 32'd1);
    drive_req(v);
    @(posedge clk);
    @(negedge clk);
    // ACCESS: scramble request inputs to prove they were captured
    req_valid = 1'b0;
    req_addr  = ~v.addr;
    req_wdata = ~v.wd;
    req_size  = ~v.sz;
    chk("acc_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("acc_req_ready", {31'h0, req_ready}, 32'd0);
    chk("acc_mem_address", mem_address, exp_addr);
    chk("acc_write_enable", {31'h0, mem_write_enable}, {31'h0, v.wr & ~v.err});
    chk("acc_byte_enable", {28'h0, mem_byte_enable}, {28'h0, v.be});
    if (v.wr && !v.err) chk("acc_write_data", mem_write_data, v.mwd);
    @(negedge clk);
    chk("resp_valid", {31'h0, rsp_valid}, 32'd1);
    chk("resp_rdata", rsp_rdata, v.rd);
    chk("resp_error", {31'h0, rsp_error}, {31'h0, v.err});
    chk("resp_write_enable", {31'h0, mem_write_enable}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

    // Vector table: wr sz uns addr wdata | be mwd rdata err
    vecs.push_back(mk(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        4'h0, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h20,  32'h11223344, 4'hF, 32'h11223344, 32'h0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h23,  32'h123456A5, 4'h8, 32'hA5A5A5A5, 32'h0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h20,  32'h0,        4'h0, 32'h0, 32'hA5223344, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h20,  32'h0,        4'h0, 32'h0, 32'h00003344, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h20,  32'h0,        4'h0, 32'h0, 32'h00000044, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h22,  32'h0,        4'h0, 32'h0, 32'hFFFFA522, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h40,  32'h80FF7F01, 4'hF, 32'h80FF7F01, 32'h0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h43,  32'h0,        4'h0, 32'h0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h43,  32'h0,        4'h0, 32'h0, 32'h00000080, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h40,  32'h0,        4'h0, 32'h0, 32'h00007F01, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h42,  32'h0,        4'h0, 32'h0, 32'hFFFF80FF, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h42,  32'h0,        4'h0, 32'h0, 32'h000080FF, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h41,  32'h0,        4'h0, 32'h0, 32'h0000007F, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h42,  32'h0,        4'h0, 32'h0, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(0, 2'b10, 1, 32'h40,  32'h0,        4'h0, 32'h0, 32'h80FF7F01, 0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h102, 32'hFFFFBEEF, 4'hC, 32'hBEEFBEEF, 32'h0, 0));
    vecs.push_back(mk(1, 2'b00, 1, 32'h100, 32'h000000C3, 4'h1, 32'hC3C3C3C3, 32'h0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h101, 32'h0000FFFF, 4'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h100, 32'h0,        4'h0, 32'h0, 32'hBEEF00C3, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h1FC, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 32'h0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h1FC, 32'h0,        4'h0, 32'h0, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h200, 32'h0,        4'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 2'b10, 0, 32'h200, 32'h12345678, 4'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0,   32'h0,        4'h0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 32'h10,  32'h0,        4'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 2'b11, 0, 32'h10,  32'h55555555, 4'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        4'h0, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h12,  32'h0,        4'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 2'b01, 0, 32'h43,  32'h0,        4'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h80000010, 32'h0,   4'h0, 32'h0, 32'h0, 1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_error", {31'h0, rsp_error}, 32'd0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_write_data", mem_write_data, 32'h0);
    chk("rst_mem_byte_enable", {28'h0, mem_byte_enable}, 32'h0);
    chk("rst_mem_write_enable", {31'h0, mem_write_enable}, 32'd0);
    nrst = 1'b1; mem_clr = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: response held for 5 cycles while a new request waits
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_req(mk(0, 2'b10, 0, 32'h40, 32'h0, 4'h0, 32'h0, 32'h0, 0));
    @(posedge clk);
    @(negedge clk);
    drive_req(mk(1, 2'b10, 0, 32'h50, 32'h99999999, 4'h0, 32'h0, 32'h0, 0));
    @(negedge clk);
    chk("bp_rise_valid", {31'h0, rsp_valid}, 32'd1);
    chk("bp_rise_rdata", rsp_rdata, 32'h80FF7F01);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'h0, rsp_valid}, 32'd1);
      chk("bp_hold_rdata", rsp_rdata, 32'h80FF7F01);
      chk("bp_hold_error", {31'h0, rsp_error}, 32'd0);
      chk("bp_hold_req_ready", {31'h0, req_ready}, 32'd0);
      chk("bp_hold_write_enable", {31'h0, mem_write_enable}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_req_ready", {31'h0, req_ready}, 32'd1);
    chk("bp_release_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("bp_release_write_enable", {31'h0, mem_write_enable}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_next_mem_address", mem_address, 32'h50);
    chk("bp_next_write_enable", {31'h0, mem_write_enable}, 32'd1);
    @(negedge clk);
    chk("bp_next_rsp_valid", {31'h0, rsp_valid}, 32'd1);
    run_vec(mk(0, 2'b10, 0, 32'h50, 32'h0, 4'h0, 32'h0, 32'h99999999, 0));

    // Reset while a response is pending
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_req(mk(1, 2'b10, 0, 32'h30, 32'h55AA55AA, 4'h0, 32'h0, 32'h0, 0));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mr_pre_rsp_valid", {31'h0, rsp_valid}, 32'd1);
    nrst = 1'b0;
    @(negedge clk);
    chk("mr_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("mr_req_ready", {31'h0, req_ready}, 32'd1);
    chk("mr_mem_address", mem_address, 32'h0);
    chk("mr_mem_write_data", mem_write_data, 32'h0);
    chk("mr_mem_byte_enable", {28'h0, mem_byte_enable}, 32'h0);
    chk("mr_mem_write_enable", {31'h0, mem_write_enable}, 32'd0);
    nrst = 1'b1;
    rsp_ready = 1'b1;
    run_vec(mk(0, 2'b10, 0, 32'h30, 32'h0, 4'h0, 32'h0, 32'h55AA55AA, 0));

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
